// File: rtl/counter_seq_if.sv
// Handshake bundle between the triangle-sweep sequencer and its counter/control side.
// The slave modport is the sequencer's view; master is the system/bench view.
interface counter_seq_if #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
);
    logic              start;
    logic              stop;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PASS_W-1:0] passes;
    logic [WIDTH-1:0]  count;
    logic              mod;
    logic              cnt_rst;
    logic              busy;
    logic              done;
    logic              rej;
    logic              err;

    modport master (
        output start, stop, lo, hi, passes, count,
        input  mod, cnt_rst, busy, done, rej, err
    );

    modport slave (
        input  start, stop, lo, hi, passes, count,
        output mod, cnt_rst, busy, done, rej, err
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving an up/down counter through a bounded triangle sweep between lo and hi,
// cross-checking the counter output against an internal shadow count.
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    counter_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [PASS_W-1:0]  passes_q, passes_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic               mod_q, mod_d;
    logic               cnt_rst_q, cnt_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rej_q, rej_d;
    logic               err_q, err_d;

    logic               cfg_bad_s;
    logic               turn_s;
    logic               last_pass_s;
    logic               mismatch_s;

    // Turnaround fires one step early so the counter lands exactly on hi/lo.
    always_comb begin
        cfg_bad_s   = (bus.hi == {WIDTH{1'b0}}) || (bus.lo >= bus.hi) ||
                      (bus.passes == {PASS_W{1'b0}});
        last_pass_s = ((pass_cnt_q + PASS_W'(1)) == passes_q);
        mismatch_s  = (bus.count != shadow_q);
        if (state_q == S_UP) begin
            turn_s = (bus.count == (hi_q - WIDTH'(1)));
        end else begin
            turn_s = (bus.count == (lo_q + WIDTH'(1)));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        passes_d   = passes_q;
        shadow_d   = shadow_q;
        pass_cnt_d = pass_cnt_q;
        mod_d      = mod_q;
        cnt_rst_d  = cnt_rst_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rej_d      = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                cnt_rst_d = 1'b1;
                mod_d     = 1'b1;
                if (bus.start) begin
                    if (cfg_bad_s) begin
                        rej_d = 1'b1;
                    end else begin
                        lo_d       = bus.lo;
                        hi_d       = bus.hi;
                        passes_d   = bus.passes;
                        shadow_d   = {WIDTH{1'b0}};
                        pass_cnt_d = {PASS_W{1'b0}};
                        cnt_rst_d  = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = S_UP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_UP, S_DOWN: begin
                shadow_d = mod_q ? (shadow_q + WIDTH'(1)) : (shadow_q - WIDTH'(1));
                if (mismatch_s) begin
                    err_d     = 1'b1;
                    cnt_rst_d = 1'b1;
                    mod_d     = 1'b1;
                    state_d   = S_ERR;
                end else if (bus.stop) begin
                    cnt_rst_d = 1'b1;
                    mod_d     = 1'b1;
                    state_d   = S_IDLE;
                end else if (turn_s) begin
                    if (last_pass_s) begin
                        // mod is left alone so the counter still reaches the final extreme.
                        cnt_rst_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + PASS_W'(1);
                        mod_d      = (state_q == S_DOWN);
                        busy_d     = 1'b1;
                        state_d    = (state_q == S_UP) ? S_DOWN : S_UP;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end

            S_DONE: begin
                cnt_rst_d = 1'b1;
                mod_d     = 1'b1;
                state_d   = S_IDLE;
            end

            S_ERR: begin
                err_d     = 1'b1;
                cnt_rst_d = 1'b1;
                mod_d     = 1'b1;
                state_d   = S_ERR;
            end

            default: begin
                cnt_rst_d = 1'b1;
                mod_d     = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lo_q       <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            passes_q   <= {PASS_W{1'b0}};
            shadow_q   <= {WIDTH{1'b0}};
            pass_cnt_q <= {PASS_W{1'b0}};
            mod_q      <= 1'b1;
            cnt_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            passes_q   <= passes_d;
            shadow_q   <= shadow_d;
            pass_cnt_q <= pass_cnt_d;
            mod_q      <= mod_d;
            cnt_rst_q  <= cnt_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rej_q      <= rej_d;
            err_q      <= err_d;
        end
    end

    assign bus.mod     = mod_q;
    assign bus.cnt_rst = cnt_rst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rej     = rej_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench: models the up/down counter, drives sweep scenarios and checks outputs.
module tb_counter_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int PASS_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] cnt_model = 4'd0;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = 4'd0;
    int               n_tests = 0;
    int               n_fail  = 0;

    counter_seq_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

    counter_seq_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference counter driven by the sequencer's mod/cnt_rst.
    always @(posedge clk) begin
        cnt_model <= bus.cnt_rst ? 4'd0 : (bus.mod ? cnt_model + 4'd1 : cnt_model - 4'd1);
    end

    assign bus.count = force_en ? force_val : cnt_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_cfg(input logic [3:0] l, input logic [3:0] h, input logic [3:0] p);
        bus.lo     = l;
        bus.hi     = h;
        bus.passes = p;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // lo=2 hi=5 passes=3 sweep; optionally pokes start/config mid-sweep.
    task automatic run_sweep(input bit disturb);
        logic [3:0] exp_cnt [12];
        logic       exp_mod [12];
        exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4, 4'd5};
        exp_mod = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        start_cfg(4'd2, 4'd5, 4'd3);
        for (int i = 0; i < 12; i++) begin
            chk4("sweep_count", bus.count, exp_cnt[i]);
            chk1("sweep_mod", bus.mod, exp_mod[i]);
            chk1("sweep_done", bus.done, (i == 11));
            chk1("sweep_busy", bus.busy, (i != 11));
            if (disturb && i == 3) begin
                bus.start  = 1'b1;
                bus.lo     = 4'd0;
                bus.hi     = 4'd9;
                bus.passes = 4'd1;
            end else begin
                bus.start  = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk4("post_done_count", bus.count, 4'd0);
        chk1("post_done_done", bus.done, 1'b0);
        chk1("post_done_busy", bus.busy, 1'b0);
        chk1("post_done_err", bus.err, 1'b0);
        chk1("post_done_cnt_rst", bus.cnt_rst, 1'b1);
        tick();
    endtask

    initial begin
        logic [3:0] rej_lo [3];
        logic [3:0] rej_hi [3];
        logic [3:0] rej_p  [3];
        logic [3:0] e5_cnt [5];
        rej_lo = '{4'd0, 4'd6, 4'd2};
        rej_hi = '{4'd0, 4'd6, 4'd5};
        rej_p  = '{4'd3, 4'd3, 4'd0};
        e5_cnt = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};

        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.lo     = 4'd0;
        bus.hi     = 4'd0;
        bus.passes = 4'd0;

        // Reset state
        repeat (3) tick();
        chk1("rst_mod", bus.mod, 1'b1);
        chk1("rst_cnt_rst", bus.cnt_rst, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_rej", bus.rej, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        tick();
        chk4("idle_count", bus.count, 4'd0);

        // Nominal sweep, then the same sweep with mid-sweep start/config changes
        run_sweep(1'b0);
        run_sweep(1'b1);

        // Invalid configurations are rejected
        for (int k = 0; k < 3; k++) begin
            start_cfg(rej_lo[k], rej_hi[k], rej_p[k]);
            chk1("rej_pulse", bus.rej, 1'b1);
            chk1("rej_busy", bus.busy, 1'b0);
            chk1("rej_cnt_rst", bus.cnt_rst, 1'b1);
            tick();
            chk1("rej_clear", bus.rej, 1'b0);
            chk1("rej_busy2", bus.busy, 1'b0);
        end

        // Stop on the way down at count=4
        start_cfg(4'd2, 4'd5, 4'd8);
        repeat (6) tick();
        chk4("stop_pre_count", bus.count, 4'd4);
        chk1("stop_pre_mod", bus.mod, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk1("stop_busy", bus.busy, 1'b0);
        chk1("stop_cnt_rst", bus.cnt_rst, 1'b1);
        chk1("stop_done", bus.done, 1'b0);
        tick();
        chk4("stop_count", bus.count, 4'd0);
        chk1("stop_done2", bus.done, 1'b0);
        tick();

        // Forced count mismatch drives ERR
        start_cfg(4'd2, 4'd5, 4'd3);
        repeat (3) tick();
        chk4("mm_pre_count", bus.count, 4'd3);
        force_val = 4'd9;
        force_en  = 1'b1;
        tick();
        force_en  = 1'b0;
        chk1("mm_err", bus.err, 1'b1);
        chk1("mm_cnt_rst", bus.cnt_rst, 1'b1);
        chk1("mm_busy", bus.busy, 1'b0);
        tick();
        chk4("mm_count", bus.count, 4'd0);
        start_cfg(4'd2, 4'd5, 4'd3);
        tick();
        chk1("mm_err_hold", bus.err, 1'b1);
        chk1("mm_start_ignored", bus.busy, 1'b0);
        chk1("mm_cnt_rst_hold", bus.cnt_rst, 1'b1);
        chk4("mm_count_hold", bus.count, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mm_rst_err", bus.err, 1'b0);
        chk1("mm_rst_mod", bus.mod, 1'b1);
        tick();

        // hi=1 lo=0 passes=4: immediate turnarounds
        start_cfg(4'd0, 4'd1, 4'd4);
        for (int i = 0; i < 5; i++) begin
            chk4("e1_count", bus.count, e5_cnt[i]);
            chk1("e1_done", bus.done, (i == 4));
            chk1("e1_busy", bus.busy, (i != 4));
            tick();
        end
        chk4("e1_after_count", bus.count, 4'd0);
        chk1("e1_after_done", bus.done, 1'b0);
        tick();

        // rst asserted during UP at count=3
        start_cfg(4'd2, 4'd5, 4'd3);
        repeat (3) tick();
        chk4("rst_mid_pre", bus.count, 4'd3);
        chk1("rst_mid_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_mid_mod", bus.mod, 1'b1);
        chk1("rst_mid_cnt_rst", bus.cnt_rst, 1'b1);
        chk1("rst_mid_busy", bus.busy, 1'b0);
        tick();
        chk4("rst_mid_count", bus.count, 4'd0);
        chk1("rst_mid_busy2", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the up/down counter datapath. It programs a bounded triangle sweep on the counter. The counter starts from 0, ramps up to hi, then bounces between hi and lo for a programmed number of direction reversals. It drives the counter's mod and rst inputs, monitors its count output against an internal shadow model, and reports done, rejected start and mismatch errors to the bench or system control.

Parameters:
WIDTH, 4, counter width in bits; lo, hi, count and shadow are all this width.
PASS_W, 4, width of the reversal-count field.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
stop  input  1  abort; sampled only in UP/DOWN.
lo  input  WIDTH  lower turnaround value; latched on start acceptance.
hi  input  WIDTH  upper turnaround value; latched on start acceptance.
passes  input  PASS_W  total direction reversals, including the final one; latched on acceptance.
count  input  WIDTH  counter output being monitored.
mod  output  1  counter direction: 1 = increment, 0 = decrement. Registered.
cnt_rst  output  1  drives counter rst, holding the counter at 0. Registered.
busy  output  1  high while in UP or DOWN.
done  output  1  one-cycle pulse when the sweep completes.
rej  output  1  one-cycle pulse when start is rejected for invalid config.
err  output  1  sticky flag set on count/shadow mismatch; cleared only by rst.

Behaviour:
- Counter model: on each edge, count <= cnt_rst ? 0 : (mod ? count+1 : count-1).
- Reset values: mod=1, cnt_rst=1, busy=0, done=0, rej=0, err=0; state=IDLE; shadow=0; pass_cnt=0.
- States: IDLE, UP, DOWN, DONE, ERR.
- IDLE:
  - cnt_rst=1, mod=1.
  - start with hi==0, lo>=hi or passes==0 -> rej pulses next cycle; stay IDLE.
  - Valid start -> latch config, shadow<=0, pass_cnt<=0, cnt_rst<=0, mod<=1, go UP. First UP cycle sees count==0.
- Shadow check:
  - In UP/DOWN, each edge: shadow <= mod ? shadow+1 : shadow-1.
  - Each UP/DOWN cycle, count!=shadow -> go ERR.
  - Mismatch takes priority over turnaround and stop.
- UP turnaround:
  - Condition: count==hi-1. Ensures the counter peaks at exactly hi.
  - If pass_cnt+1==passes -> go DONE, cnt_rst<=1.
  - Else mod<=0, pass_cnt++, go DOWN.
- DOWN turnaround:
  - Condition: count==lo+1.
  - Same handling as UP, but mod<=1 and go UP.
- DONE:
  - done=1 for exactly one cycle while count still equals the final extreme.
  - Then go IDLE; count reads 0 from the following cycle.
- ERR:
  - err=1 sticky, cnt_rst=1, busy=0.
  - Stays in ERR until rst; start is ignored.
- stop in UP/DOWN (no mismatch) -> IDLE, cnt_rst<=1, mod<=1, no done pulse.
- start while busy is ignored; config changes while busy are ignored (latched copy is used).
- rst asserted mid-sweep -> all reset values on the next edge, regardless of state.
- Arithmetic:
  - hi-1 and lo+1 are WIDTH-bit.
  - Valid configs never wrap: hi>=1 and lo<hi, so lo+1<=hi.
- Boundary cases:
  - hi=1 -> turnaround in the first UP cycle.
  - lo=hi-1 -> DOWN turns in its first cycle.
  - lo=0 is legal.

Test Plan:
- lo=2, hi=5, passes=3, start pulse:
  - count reads 0,1,2,3,4,5,4,3,2,3,4,5 in successive cycles, mod tracking direction;
  - done high only in the cycle count=5 (second peak);
  - busy low from that cycle; count=0 the cycle after; err=0.
- hi=0 or lo=6/hi=6 or passes=0 with start -> rej pulses one cycle; cnt_rst stays 1; busy never rises.
- lo=2, hi=5, passes=8, stop asserted when count=4 on the way down -> next cycle busy=0 and cnt_rst=1; count=0 one cycle later; no done.
- Mid-sweep, bench forces count to 9 for one cycle (shadow=3) -> ERR next cycle; err=1 and cnt_rst=1 held; a following start is ignored; only rst clears err.
- Edge cases:
  - hi=1, lo=0, passes=4 -> count 0,1,0,1,0; done in the last 0-valued cycle.
  - Assert rst during UP at count=3 -> mod=1, cnt_rst=1, busy=0 next cycle; count=0 after.
- start pulsed while busy, and lo/hi changed mid-sweep -> sweep unaffected; latched values used throughout.
